inst_fetch_cache: RTL and testbench
===================================

# inst_fetch_cache

Direct-mapped instruction cache between the pipeline's fetch stage and slow backing instruction storage. Each cycle it looks up the fetch PC and returns the instruction combinationally on a hit. On a miss it raises `stall` and refills the whole line through a request/valid handshake with backing memory. It drives the pipeline's `if_inst_out` and `stall` inputs from the pipeline's `if_pc_in` output.

## Interface
Parameters:
- `LINES`, 16: number of cache lines; power of two, at least 2.
- `LINE_WORDS`, 4: 32-bit words per line; power of two, at least 2.

Ports:
- `clk` in 1: clock. All state updates on the rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `pc_in` in 32: fetch address. Bits [1:0] are ignored.
- `inst_out` out 32: instruction at `pc_in` on a hit, 0 otherwise.
- `stall` out 1: high whenever there is no hit.
- `mem_req` out 1: refill request, level-held.
- `mem_addr` out 32: word address being requested; bits [1:0] = 0.
- `mem_valid` in 1: `mem_rdata` is valid for the current `mem_addr`.
- `mem_rdata` in 32: refill data.
- `hit_cnt` out 32: count of hit cycles.
- `miss_cnt` out 32: count of misses.

## Operation
Address split, with OFF = log2(LINE_WORDS)+2 and IDX = log2(LINES):
- word select = `pc[OFF-1:2]`
- index = `pc[OFF+IDX-1:OFF]`
- tag = `pc[31:OFF+IDX]`
- Defaults: word [3:2], index [7:4], tag [31:8].

Lookup (combinational):
- `hit` = `valid[idx]` && `tag_arr[idx] == tag` && state == IDLE.
- `inst_out` = hit ? `data[idx][word]` : 0.
- `stall` = !hit.

FSM states: IDLE, FILL.
- IDLE, no hit: latch `miss_base` = `{pc_in[31:OFF], OFF'b0}`. Clear `valid[idx]`, set `cnt` = 0, increment `miss_cnt`, go to FILL.
- IDLE, hit: increment `hit_cnt`.
- FILL: `mem_req` = 1 and `mem_addr` = `miss_base + cnt*4`.
  - On each cycle with `mem_valid`: write `mem_rdata` to `data[line][cnt]`, then increment `cnt`.
  - When `cnt == LINE_WORDS-1` and `mem_valid`: set `valid` and `tag_arr` for the line, go to IDLE.
- In IDLE, `mem_req` = 0 and `mem_addr` = 0.
- `mem_valid` is ignored outside FILL.
- `cnt` wraps only by leaving FILL.

Counters are 32-bit and wrap modulo 2^32.

## Timing
- Hit latency is 0 cycles: `inst_out` is combinational from `pc_in`.
- Miss penalty is 1 detection edge plus one edge per accepted word. With `mem_valid` tied high, that is LINE_WORDS+1 cycles of `stall`. The first hit is in the cycle after the last-word edge.
- `mem_valid` may be high in the same cycle that `mem_req` first rises (zero-wait memory).
- `pc_in` changes during FILL (branch redirect) are ignored. The refill completes for the latched line, then IDLE re-evaluates the current `pc_in`. If it misses, the next refill starts on that edge.
- Reset mid-FILL: go to IDLE, clear all `valid`, and clear both counters. `mem_req` is low in the cycle after the reset edge. A late `mem_valid` is ignored.
- Reset values: state IDLE, all `valid` = 0, `cnt` = 0, `hit_cnt` = `miss_cnt` = 0, `mem_req` = 0, `mem_addr` = 0.
  - After reset every lookup misses, so `inst_out` = 0 and `stall` = 1 until the first refill completes.
- Data and tag arrays are not reset.
- Index conflict: a refill overwrites the resident line unconditionally; no write-back is needed.

## Structure
- Package `inst_fetch_cache_pkg` holds:
  - the FSM state enum (IDLE, FILL);
  - localparam functions deriving OFF, IDX and tag width from LINES/LINE_WORDS.
- Sub-module `icache_line_array` holds the valid/tag/data storage:
  - combinational read port (index, word) returning valid, tag and data;
  - synchronous word-write port;
  - line-validate port;
  - invalidate-all on reset.
- The top level holds the FSM, `cnt`, `miss_base` and the counters.

## Test plan
- After reset, `pc_in` = 0x0000_0000 with a zero-wait memory returning word = addr+0x100:
  - `stall` = 1 for 5 cycles;
  - `mem_addr` sequence 0x0, 0x4, 0x8, 0xC;
  - then `inst_out` = 0x100 and `stall` = 0; `miss_cnt` = 1.
- Sequential `pc_in` 0x4, 0x8, 0xC after that fill: `inst_out` = 0x104, 0x108, 0x10C with no stall; `hit_cnt` increments by 3.
- Conflict: `pc_in` = 0x100 (same index 0, tag 1) misses and refills from 0x100. Returning to `pc_in` = 0x0 then misses again; `miss_cnt` = 3.
- Memory asserting `mem_valid` every 3rd cycle: `mem_addr` holds each value until accepted, and the fill takes 12 cycles plus detection.
- Redirect: `pc_in` changes 0x20 → 0x40 during FILL. The line at 0x20 completes and becomes valid, then a new refill starts at 0x40 on the following edge.
- Reset asserted on the 2nd word of a fill: the next cycle shows `mem_req` = 0 and counters 0. Re-requesting the same PC misses and performs a full 4-word refill.

Source files
------------

// File: rtl/inst_fetch_cache_pkg.sv
// rtl/inst_fetch_cache_pkg.sv - shared state type and address-split helpers for the fetch cache
package inst_fetch_cache_pkg;

  typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_e;

  function automatic int calc_off(input int line_words);
    return $clog2(line_words) + 2;
  endfunction

  function automatic int calc_idx(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int calc_tag(input int lines, input int line_words);
    return 32 - calc_off(line_words) - calc_idx(lines);
  endfunction

endpackage

// File: rtl/icache_line_array.sv
// rtl/icache_line_array.sv - valid/tag/data storage with combinational read and synchronous update
module icache_line_array
  import inst_fetch_cache_pkg::*;
#(
  parameter  int LINES      = 16,
  parameter  int LINE_WORDS = 4,
  localparam int IDX        = calc_idx(LINES),
  localparam int WSEL       = $clog2(LINE_WORDS),
  localparam int TAG_W      = calc_tag(LINES, LINE_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX-1:0]   rd_idx,
  input  logic [WSEL-1:0]  rd_word,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_data,
  input  logic             wr_en,
  input  logic [IDX-1:0]   wr_idx,
  input  logic [WSEL-1:0]  wr_word,
  input  logic [31:0]      wr_data,
  input  logic             inv_en,
  input  logic [IDX-1:0]   inv_idx,
  input  logic             val_en,
  input  logic [IDX-1:0]   val_idx,
  input  logic [TAG_W-1:0] val_tag
);

  logic [LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [TAG_W-1:0] tag_d  [LINES];
  logic [31:0]      data_q [LINES][LINE_WORDS];
  logic [31:0]      data_d [LINES][LINE_WORDS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx][rd_word];

  // Tags and data are deliberately left unreset; only valid bits gate use.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (inv_en) valid_d[inv_idx] = 1'b0;
    if (val_en) begin
      valid_d[val_idx] = 1'b1;
      tag_d[val_idx]   = val_tag;
    end
    if (wr_en) data_d[wr_idx][wr_word] = wr_data;
    if (reset) valid_d = '0;
  end

  always_ff @(posedge clk) begin
    valid_q <= valid_d;
    tag_q   <= tag_d;
    data_q  <= data_d;
  end

endmodule

// File: rtl/inst_fetch_cache.sv
// rtl/inst_fetch_cache.sv - direct-mapped instruction cache with whole-line refill FSM
module inst_fetch_cache
  import inst_fetch_cache_pkg::*;
#(
  parameter int LINES      = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic [31:0] inst_out,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int OFF   = calc_off(LINE_WORDS);
  localparam int IDX   = calc_idx(LINES);
  localparam int TAG_W = calc_tag(LINES, LINE_WORDS);
  localparam int WSEL  = OFF - 2;
  localparam logic [WSEL-1:0] LAST_WORD = WSEL'(LINE_WORDS - 1);

  state_e         state_q, state_d;
  logic [WSEL-1:0] cnt_q, cnt_d;
  logic [31:0]    miss_base_q, miss_base_d;
  logic [31:0]    hit_cnt_q, hit_cnt_d;
  logic [31:0]    miss_cnt_q, miss_cnt_d;
  logic           mem_req_q, mem_req_d;
  logic [31:0]    mem_addr_q, mem_addr_d;

  logic [WSEL-1:0]  pc_word;
  logic [IDX-1:0]   pc_idx, fill_idx;
  logic [TAG_W-1:0] pc_tag, fill_tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_data;
  logic             hit;
  logic             wr_en, inv_en, val_en;
  logic [31:0]      next_addr;
  logic             unused_pc_bits;

  assign pc_word        = pc_in[OFF-1:2];
  assign pc_idx         = pc_in[OFF+IDX-1:OFF];
  assign pc_tag         = pc_in[31:OFF+IDX];
  assign fill_idx       = miss_base_q[OFF+IDX-1:OFF];
  assign fill_tag       = miss_base_q[31:OFF+IDX];
  assign unused_pc_bits = ^pc_in[1:0];

  icache_line_array #(
    .LINES      (LINES),
    .LINE_WORDS (LINE_WORDS)
  ) u_lines (
    .clk      (clk),
    .reset    (reset),
    .rd_idx   (pc_idx),
    .rd_word  (pc_word),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (fill_idx),
    .wr_word  (cnt_q),
    .wr_data  (mem_rdata),
    .inv_en   (inv_en),
    .inv_idx  (pc_idx),
    .val_en   (val_en),
    .val_idx  (fill_idx),
    .val_tag  (fill_tag)
  );

  assign hit      = rd_valid && (rd_tag == pc_tag) && (state_q == IDLE);
  assign inst_out = hit ? rd_data : 32'd0;
  assign stall    = !hit;
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // mem_addr is registered, so it is loaded one word ahead of each acceptance.
  assign next_addr = miss_base_q + ((32'(cnt_q) + 32'd1) << 2);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    miss_base_d = miss_base_q;
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    wr_en       = 1'b0;
    inv_en      = 1'b0;
    val_en      = 1'b0;
    if (reset) begin
      state_d     = IDLE;
      cnt_d       = '0;
      miss_base_d = 32'd0;
      hit_cnt_d   = 32'd0;
      miss_cnt_d  = 32'd0;
      mem_req_d   = 1'b0;
      mem_addr_d  = 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hit) begin
            hit_cnt_d = hit_cnt_q + 32'd1;
          end else begin
            miss_base_d = {pc_in[31:OFF], {OFF{1'b0}}};
            inv_en      = 1'b1;
            cnt_d       = '0;
            miss_cnt_d  = miss_cnt_q + 32'd1;
            state_d     = FILL;
            mem_req_d   = 1'b1;
            mem_addr_d  = miss_base_d;
          end
        end
        FILL: begin
          if (mem_valid) begin
            wr_en = 1'b1;
            cnt_d = cnt_q + WSEL'(1);
            if (cnt_q == LAST_WORD) begin
              val_en     = 1'b1;
              state_d    = IDLE;
              mem_req_d  = 1'b0;
              mem_addr_d = 32'd0;
            end else begin
              mem_addr_d = next_addr;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q     <= state_d;
    cnt_q       <= cnt_d;
    miss_base_q <= miss_base_d;
    hit_cnt_q   <= hit_cnt_d;
    miss_cnt_q  <= miss_cnt_d;
    mem_req_q   <= mem_req_d;
    mem_addr_q  <= mem_addr_d;
  end

endmodule

// File: tb/tb_inst_fetch_cache.sv
// tb/tb_inst_fetch_cache.sv - scoreboard bench for inst_fetch_cache
module tb_inst_fetch_cache;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] pc_in = 32'd0;
  logic [31:0] inst_out;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_valid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;

  int errors = 0;
  int checks = 0;
  int exp_hits = 0;
  int exp_misses = 0;
  int rc = 0;
  bit slow_mode = 1'b0;
  bit force_valid = 1'b0;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_inst_q[$];

  inst_fetch_cache #(.LINES(16), .LINE_WORDS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .pc_in     (pc_in),
    .inst_out  (inst_out),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_valid (mem_valid),
    .mem_rdata (mem_rdata),
    .hit_cnt   (hit_cnt),
    .miss_cnt  (miss_cnt)
  );

  always #5 clk = ~clk;

  // One clock: after the edge, drive the memory response and score the request address.
  task automatic step();
    logic [31:0] want;
    @(posedge clk);
    #1;
    if (mem_req === 1'b1) rc++; else rc = 0;
    mem_valid = force_valid || ((mem_req === 1'b1) && (!slow_mode || (rc % 3 == 0)));
    mem_rdata = mem_addr + 32'h100;
    #1;
    if (mem_req === 1'b1) begin
      checks++;
      if (exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL mem_addr_unexpected: got %h, required no request", mem_addr);
      end else begin
        want = exp_addr_q[0];
        if (mem_addr !== want) begin
          errors++;
          $display("FAIL mem_addr: got %h, required %h", mem_addr, want);
        end
        if (mem_valid) void'(exp_addr_q.pop_front());
      end
    end
  endtask

  task automatic do_miss(input logic [31:0] pc, input int exp_stall);
    logic [31:0] base;
    logic [31:0] want;
    int n;
    base = {pc[31:4], 4'h0};
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(base + 32'(4 * i));
    exp_inst_q.push_back({pc[31:2], 2'b00} + 32'h100);
    exp_misses++;
    pc_in = pc;
    #1;
    n = 0;
    while (stall !== 1'b0 && n < 200) begin
      n++;
      step();
    end
    checks++;
    if (n !== exp_stall) begin
      errors++;
      $display("FAIL stall_cycles pc=%h: got %0d, required %0d", pc, n, exp_stall);
    end
    want = exp_inst_q.pop_front();
    checks++;
    if (inst_out !== want || stall !== 1'b0) begin
      errors++;
      $display("FAIL fill_hit pc=%h: got inst=%h stall=%b, required inst=%h stall=0", pc, inst_out, stall, want);
    end
    checks++;
    if (exp_addr_q.size() != 0) begin
      errors++;
      $display("FAIL fill_words pc=%h: got %0d words outstanding, required 0", pc, exp_addr_q.size());
    end
  endtask

  task automatic check_counts(input string name);
    checks++;
    if (hit_cnt !== 32'(exp_hits) || miss_cnt !== 32'(exp_misses)) begin
      errors++;
      $display("FAIL %s counters: got hit=%0d miss=%0d, required hit=%0d miss=%0d",
               name, hit_cnt, miss_cnt, exp_hits, exp_misses);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    pc_in = 32'd0;
    step();
    step();
    reset = 1'b0;
    #1;
    checks++;
    if (stall !== 1'b1 || inst_out !== 32'd0 || mem_req !== 1'b0 || mem_addr !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got stall=%b inst=%h req=%b addr=%h, required 1 0 0 0",
               stall, inst_out, mem_req, mem_addr);
    end
    check_counts("reset");
  endtask

  task automatic test_cold_fill();
    do_miss(32'h0, 5);
    check_counts("cold_fill");
  endtask

  task automatic test_sequential_hits();
    logic [31:0] want;
    for (int i = 1; i < 4; i++) begin
      pc_in = 32'(4 * i);
      exp_inst_q.push_back(32'(4 * i) + 32'h100);
      #1;
      want = exp_inst_q.pop_front();
      checks++;
      if (inst_out !== want || stall !== 1'b0) begin
        errors++;
        $display("FAIL seq_hit pc=%h: got inst=%h stall=%b, required inst=%h stall=0", pc_in, inst_out, stall, want);
      end
      step();
      exp_hits++;
    end
    check_counts("sequential");
  endtask

  task automatic test_conflict();
    do_miss(32'h100, 5);
    do_miss(32'h0, 5);
    check_counts("conflict");
  endtask

  task automatic test_slow_memory();
    slow_mode = 1'b1;
    do_miss(32'h1A0, 13);
    slow_mode = 1'b0;
    check_counts("slow_memory");
  endtask

  task automatic test_redirect();
    int n;
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(32'h20 + 32'(4 * i));
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(32'h40 + 32'(4 * i));
    exp_misses += 2;
    pc_in = 32'h20;
    step();
    pc_in = 32'h40;
    repeat (4) step();
    checks++;
    if (stall !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL redirect_idle: got stall=%b req=%b, required stall=1 req=0", stall, mem_req);
    end
    step();
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL redirect_refill: got req=%b, required 1", mem_req);
    end
    n = 0;
    while (stall !== 1'b0 && n < 50) begin
      n++;
      step();
    end
    checks++;
    if (n !== 4 || inst_out !== 32'h140) begin
      errors++;
      $display("FAIL redirect_fill: got cycles=%0d inst=%h, required 4 and 00000140", n, inst_out);
    end
    pc_in = 32'h20;
    #1;
    checks++;
    if (inst_out !== 32'h120 || stall !== 1'b0) begin
      errors++;
      $display("FAIL redirect_old_line: got inst=%h stall=%b, required 00000120 and 0", inst_out, stall);
    end
    check_counts("redirect");
  endtask

  task automatic test_reset_mid_fill();
    exp_addr_q.push_back(32'h300);
    exp_addr_q.push_back(32'h304);
    pc_in = 32'h300;
    step();
    step();
    reset = 1'b1;
    force_valid = 1'b1;
    step();
    exp_hits = 0;
    exp_misses = 0;
    checks++;
    if (mem_req !== 1'b0 || mem_addr !== 32'd0 || stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_fill: got req=%b addr=%h stall=%b, required 0 0 1", mem_req, mem_addr, stall);
    end
    check_counts("reset_mid_fill");
    reset = 1'b0;
    force_valid = 1'b0;
    exp_addr_q.delete();
    pc_in = 32'h0;
    #1;
    checks++;
    if (stall !== 1'b1 || inst_out !== 32'd0) begin
      errors++;
      $display("FAIL reset_invalidates: got stall=%b inst=%h, required 1 and 0", stall, inst_out);
    end
    do_miss(32'h300, 5);
    check_counts("refill_after_reset");
  endtask

  initial begin
    test_reset();
    test_cold_fill();
    test_sequential_hits();
    test_conflict();
    test_slow_memory();
    test_redirect();
    test_reset_mid_fill();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
